// File: rtl/serial_add_sub.sv
// Bit-serial LSB-first adder/subtractor: one add/sub cell and a carry/borrow flop
// reused over WIDTH cycles, with a start/busy/done handshake.
module serial_add_sub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sa, sb, sr, sr_nx;
    logic [CW-1:0]    cnt;
    logic             op_q, c;
    logic             bit_s, bit_c, last, accept;

    always_comb begin
        bit_s = sa[0] ^ sb[0] ^ c;
        if (op_q)
            bit_c = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & c);
        else
            bit_c = (sa[0] & sb[0]) | ((sa[0] ^ sb[0]) & c);
        last = (cnt == CW'(WIDTH - 1));
    end

    // New bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_w1
            always_comb sr_nx = bit_s;
        end else begin : g_wn
            always_comb sr_nx = {bit_s, sr[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (last)
                    state_nx = DONE;
            end
            DONE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            sr     <= '0;
            op_q   <= 1'b0;
            c      <= 1'b0;
            cnt    <= '0;
            result <= '0;
            flag   <= 1'b0;
        end else if (accept) begin
            sa   <= a;
            sb   <= b;
            sr   <= '0;
            op_q <= op;
            c    <= 1'b0;
            cnt  <= '0;
        end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            sr  <= sr_nx;
            c   <= bit_c;
            cnt <= cnt + CW'(1);
            // Visible outputs change only on the final bit, never on partial sums.
            if (last) begin
                result <= sr_nx;
                flag   <= bit_c;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub: WIDTH=8 instance for timing/handshake cases,
// WIDTH=1 instance for the exhaustive half-adder/half-subtractor table.
module tb_serial_add_sub;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0, op8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, flag8;
    logic [7:0] res8;

    logic       start1 = 1'b0, op1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, flag1;
    logic [0:0] res1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(res8), .flag(flag8)
    );

    serial_add_sub #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op(op1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .result(res1), .flag(flag1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for one edge; returns #1 after the accepting edge.
    task automatic go8(input logic o, input logic [7:0] x, input logic [7:0] y);
        op8 = o; a8 = x; b8 = y; start8 = 1'b1;
        tick();
        start8 = 1'b0;
    endtask

    // Count edges until done is seen; 99 means the bound expired.
    task automatic wait_done8(output int n);
        n = 99;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done8) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic op_case8(input string tag, input logic o, input logic [7:0] x,
                            input logic [7:0] y, input logic [7:0] er, input logic ef);
        int n;
        go8(o, x, y);
        check({tag, "_busy"}, busy8, 1'b1);
        wait_done8(n);
        check({tag, "_lat"}, n, 8);
        check({tag, "_res"}, res8, er);
        check({tag, "_flag"}, flag8, ef);
        check({tag, "_busy_at_done"}, busy8, 1'b0);
        tick();
        check({tag, "_done_width"}, done8, 1'b0);
    endtask

    logic [7:0] res_save;
    int n;
    logic seen;
    logic [2:0] v;
    logic ea, eb, eo;

    initial begin
        #12;
        check("rst_busy", busy8, 1'b0);
        check("rst_done", done8, 1'b0);
        check("rst_res", res8, 8'h00);
        check("rst_flag", flag8, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        op_case8("add3c45", 1'b0, 8'h3C, 8'h45, 8'h81, 1'b0);
        op_case8("addff01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1);
        op_case8("sub0507", 1'b1, 8'h05, 8'h07, 8'hFE, 1'b1);
        op_case8("sub8101", 1'b1, 8'h81, 8'h01, 8'h80, 1'b0);

        // start during RUN with new operands must be ignored
        go8(1'b0, 8'h7F, 8'h7F);
        tick(); tick();
        op8 = 1'b1; a8 = 8'h00; b8 = 8'h01; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check("midrun_no_done", done8, 1'b0);
        check("midrun_res_hold", res8, 8'h80);
        wait_done8(n);
        check("midrun_lat", n + 3, 8);
        check("midrun_res", res8, 8'hFE);
        check("midrun_flag", flag8, 1'b0);
        tick();

        // reset during RUN aborts without done
        go8(1'b0, 8'h3C, 8'h45);
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy8, 1'b0);
        check("abort_done", done8, 1'b0);
        check("abort_res", res8, 8'h00);
        check("abort_flag", flag8, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8) seen = 1'b1;
        end
        check("abort_no_done", seen, 1'b0);
        op_case8("after_rst", 1'b0, 8'h12, 8'h34, 8'h46, 1'b0);

        // back-to-back: start in the DONE cycle
        go8(1'b0, 8'hC8, 8'h64);
        wait_done8(n);
        check("b2b_lat1", n, 8);
        check("b2b_res1", res8, 8'h2C);
        check("b2b_flag1", flag8, 1'b1);
        op8 = 1'b1; a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check("b2b_busy2", busy8, 1'b1);
        check("b2b_done_drop", done8, 1'b0);
        check("b2b_res_hold", res8, 8'h2C);
        wait_done8(n);
        check("b2b_lat2", n, 8);
        check("b2b_res2", res8, 8'hF0);
        check("b2b_flag2", flag8, 1'b1);
        tick();

        // WIDTH=1: exhaustive, start held high so every DONE re-launches
        for (int k = 0; k < 8; k++) begin
            v = 3'(k);
            eo = v[2]; ea = v[1]; eb = v[0];
            op1 = eo; a1 = ea; b1 = eb; start1 = 1'b1;
            tick();
            check($sformatf("w1_busy_%0d", k), busy1, 1'b1);
            op1 = ~eo; a1 = ~ea; b1 = ~eb;
            tick();
            check($sformatf("w1_done_%0d", k), done1, 1'b1);
            check($sformatf("w1_res_%0d", k), res1, ea ^ eb);
            check($sformatf("w1_flag_%0d", k), flag1, eo ? (~ea & eb) : (ea & eb));
        end
        start1 = 1'b0;
        tick();
        check("w1_idle_done", done1, 1'b0);
        check("w1_idle_busy", busy1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
